ov5640_dvp_capture: RTL and testbench

//  Downstream of ov5640_top: samples the OV5640 8-bit DVP bus (pclk/href/vsync/data) and

---
 rtl/ov5640_dvp_capture.sv | 180 ++++++++++++++++++
 tb/tb_ov5640_dvp_capture.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_dvp_capture.sv
// OV5640 8-bit DVP capture: pairs bytes into RGB565 pixels with frame/line markers and coordinates.
// Drops settling frames after enable and only starts output on a frame boundary.
module ov5640_dvp_capture #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SKIP_FRAMES = 10
) (
  input  logic        ov5640_pclk,
  input  logic        s_rst_n,
  input  logic        ov5640_href,
  input  logic        ov5640_vsync,
  input  logic [7:0]  ov5640_data,
  input  logic        cap_en,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_done,
  output logic        cap_err
);

  localparam int unsigned CW = 12;
  localparam int unsigned SW = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    WAIT_VS = 2'd2,
    CAP     = 2'd3
  } state_t;

  state_t          state;
  logic            href_r;
  logic            href_r_d;
  logic            vs_r;
  logic            vs_r_d;
  logic [7:0]      d_r;
  logic [SW-1:0]   skip_cnt;
  logic [CW-1:0]   x_cnt;
  logic [CW-1:0]   y_cnt;
  logic            phase;
  logic [7:0]      hi_byte;

  logic            vs_rise;
  logic            href_fall;
  logic            line_end;
  logic            byte_ok;
  logic            line_bad;
  logic [CW-1:0]   y_close;

  assign vs_rise   = vs_r & ~vs_r_d;
  assign href_fall = href_r_d & ~href_r;
  // A line only counts if it ended while the frame was still open
  assign line_end  = href_fall & ~vs_r_d;
  assign byte_ok   = href_r & ~vs_r;
  assign line_bad  = phase | (x_cnt != CW'(H_ACTIVE));
  assign y_close   = y_cnt + {{(CW-1){1'b0}}, line_end};

  // Input sampling stage
  always_ff @(posedge ov5640_pclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      href_r   <= 1'b0;
      href_r_d <= 1'b0;
      vs_r     <= 1'b0;
      vs_r_d   <= 1'b0;
      d_r      <= 8'd0;
    end else begin
      href_r   <= ov5640_href;
      href_r_d <= href_r;
      vs_r     <= ov5640_vsync;
      vs_r_d   <= vs_r;
      d_r      <= ov5640_data;
    end
  end

  // Control FSM, byte pairing, coordinate tracking and registered outputs
  always_ff @(posedge ov5640_pclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state      <= IDLE;
      skip_cnt   <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      phase      <= 1'b0;
      hi_byte    <= 8'd0;
      pix_valid  <= 1'b0;
      pix_data   <= 16'd0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
      cap_err    <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          cap_err  <= 1'b0;
          skip_cnt <= '0;
          x_cnt    <= '0;
          y_cnt    <= '0;
          phase    <= 1'b0;
          if (cap_en) state <= SKIP;
        end

        SKIP: begin
          if (!cap_en) begin
            state <= IDLE;
          end else if (SKIP_FRAMES == 32'd0) begin
            state <= WAIT_VS;
          end else if (vs_rise) begin
            if ((32'(skip_cnt) + 32'd1) >= SKIP_FRAMES) begin
              state <= CAP;
              x_cnt <= '0;
              y_cnt <= '0;
              phase <= 1'b0;
            end else begin
              skip_cnt <= skip_cnt + SW'(1);
            end
          end
        end

        WAIT_VS: begin
          if (!cap_en) begin
            state <= IDLE;
          end else if (vs_rise) begin
            state <= CAP;
            x_cnt <= '0;
            y_cnt <= '0;
            phase <= 1'b0;
          end
        end

        CAP: begin
          if (vs_rise) begin
            // Frame close: check geometry, abandon any partial line, restart counters
            frame_done <= 1'b1;
            if ((y_close != CW'(V_ACTIVE)) || href_r || (line_end && line_bad))
              cap_err <= 1'b1;
            x_cnt <= '0;
            y_cnt <= '0;
            phase <= 1'b0;
            if (!cap_en) state <= IDLE;
          end else if (line_end) begin
            if (line_bad) cap_err <= 1'b1;
            x_cnt <= '0;
            phase <= 1'b0;
            if (y_cnt != {CW{1'b1}}) y_cnt <= y_cnt + CW'(1);
          end else if (byte_ok) begin
            if (!phase) begin
              hi_byte <= d_r;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if ((x_cnt < CW'(H_ACTIVE)) && (y_cnt < CW'(V_ACTIVE))) begin
                pix_valid <= 1'b1;
                pix_data  <= {hi_byte, d_r};
                pix_x     <= x_cnt;
                pix_y     <= y_cnt;
                pix_sof   <= (x_cnt == '0) && (y_cnt == '0);
                pix_eol   <= (x_cnt == CW'(H_ACTIVE - 1));
                x_cnt     <= x_cnt + CW'(1);
              end else begin
                cap_err <= 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// Directed bench for ov5640_dvp_capture with a 4x2 frame and two settling frames.
module tb_ov5640_dvp_capture;

  logic        clk;
  logic        s_rst_n;
  logic        href;
  logic        vsync;
  logic [7:0]  data;
  logic        cap_en;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        frame_done;
  logic        cap_err;

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eol;
    logic [11:0] x;
    logic [11:0] y;
  } pix_t;

  pix_t q[$];
  int   fd_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  ov5640_dvp_capture #(
    .H_ACTIVE(4),
    .V_ACTIVE(2),
    .SKIP_FRAMES(2)
  ) dut (
    .ov5640_pclk (clk),
    .s_rst_n     (s_rst_n),
    .ov5640_href (href),
    .ov5640_vsync(vsync),
    .ov5640_data (data),
    .cap_en      (cap_en),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_done  (frame_done),
    .cap_err     (cap_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel / frame_done collector
  always @(negedge clk) begin
    if (pix_valid) q.push_back({pix_data, pix_sof, pix_eol, pix_x, pix_y});
    if (frame_done) fd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] base);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      href = 1'b1;
      data = 8'(base + i);
    end
    @(negedge clk);
    href = 1'b0;
    data = 8'd0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_vsync();
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] base);
    send_line(8, base);
    send_line(8, 8'(base + 8));
    send_vsync();
  endtask

  // Expect a clean 4x2 frame of sequential bytes starting at base
  task automatic check_frame(input string tag, input logic [7:0] base);
    check({tag, "_cnt"}, 32'(q.size()), 32'd8);
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      logic [7:0] hb;
      logic [7:0] lb;
      hb = 8'(base + 2 * i);
      lb = 8'(base + 2 * i + 1);
      check($sformatf("%s_d%0d", tag, i), 32'(q[i].d), {16'd0, hb, lb});
      check($sformatf("%s_x%0d", tag, i), 32'(q[i].x), 32'(i % 4));
      check($sformatf("%s_y%0d", tag, i), 32'(q[i].y), 32'(i / 4));
      check($sformatf("%s_sof%0d", tag, i), 32'(q[i].sof), 32'(i == 0));
      check($sformatf("%s_eol%0d", tag, i), 32'(q[i].eol), 32'(i % 4 == 3));
    end
    q.delete();
  endtask

  task automatic skip_two(input string tag);
    int fd0;
    fd0 = fd_cnt;
    q.delete();
    send_frame(8'h00);
    send_frame(8'h00);
    check({tag, "_skip_pix"}, 32'(q.size()), 32'd0);
    check({tag, "_skip_fd"}, 32'(fd_cnt - fd0), 32'd0);
  endtask

  initial begin
    s_rst_n = 1'b0;
    href    = 1'b0;
    vsync   = 1'b0;
    data    = 8'd0;
    cap_en  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_data", 32'(pix_data), 32'd0);
    check("rst_sof", 32'(pix_sof), 32'd0);
    check("rst_eol", 32'(pix_eol), 32'd0);
    check("rst_x", 32'(pix_x), 32'd0);
    check("rst_y", 32'(pix_y), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_err", 32'(cap_err), 32'd0);
    s_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Settling frames dropped, third frame captured
    cap_en = 1'b1;
    skip_two("t1");
    send_frame(8'h00);
    check_frame("t1_f3", 8'h00);
    check("t1_fd", 32'(fd_cnt), 32'd1);
    check("t1_err", 32'(cap_err), 32'd0);
    send_frame(8'h00);
    check("t1_f4_cnt", 32'(q.size()), 32'd8);
    check("t1_f4_fd", 32'(fd_cnt), 32'd2);
    q.delete();

    // Pixel appears one edge after its low byte is sampled
    @(negedge clk);
    href = 1'b1;
    data = 8'hAB;
    @(negedge clk);
    data = 8'hCD;
    @(posedge clk);
    #1 check("t2_lat_k", 32'(pix_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t2_lat_valid", 32'(pix_valid), 32'd1);
    check("t2_lat_data", 32'(pix_data), 32'h0000ABCD);
    check("t2_lat_sof", 32'(pix_sof), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data = 8'(8'h11 + i);
    end
    @(negedge clk);
    href = 1'b0;
    data = 8'd0;
    repeat (3) @(negedge clk);
    send_line(8, 8'h50);
    send_vsync();
    check("t2_cnt", 32'(q.size()), 32'd8);
    if (q.size() >= 4) begin
      check("t2_p1", 32'(q[1].d), 32'h0000CD11);
      check("t2_p3", 32'(q[3].d), 32'h00001415);
      check("t2_p3_eol", 32'(q[3].eol), 32'd1);
    end
    check("t2_err", 32'(cap_err), 32'd0);
    q.delete();

    // Odd-length line: last byte dropped, next line restarts at x=0
    send_line(7, 8'h20);
    check("t3_err", 32'(cap_err), 32'd1);
    check("t3_cnt0", 32'(q.size()), 32'd3);
    send_line(8, 8'h30);
    cap_en = 1'b0;
    send_vsync();
    check("t3_cnt", 32'(q.size()), 32'd7);
    if (q.size() >= 4) begin
      check("t3_p2", 32'(q[2].d), 32'h00002425);
      check("t3_p3", 32'(q[3].d), 32'h00003031);
      check("t3_p3_x", 32'(q[3].x), 32'd0);
      check("t3_p3_y", 32'(q[3].y), 32'd1);
    end
    check("t3_err_clr", 32'(cap_err), 32'd0);
    q.delete();

    // Over-long line: fifth pixel dropped
    cap_en = 1'b1;
    skip_two("t4a");
    send_line(10, 8'h40);
    check("t4a_err", 32'(cap_err), 32'd1);
    send_line(8, 8'h60);
    cap_en = 1'b0;
    send_vsync();
    check("t4a_cnt", 32'(q.size()), 32'd8);
    if (q.size() >= 5) begin
      check("t4a_p3", 32'(q[3].d), 32'h00004647);
      check("t4a_p3_eol", 32'(q[3].eol), 32'd1);
      check("t4a_p4", 32'(q[4].d), 32'h00006061);
      check("t4a_p4_x", 32'(q[4].x), 32'd0);
    end
    q.delete();

    // Extra line in a frame: dropped and flagged
    cap_en = 1'b1;
    skip_two("t4b");
    send_line(8, 8'h70);
    send_line(8, 8'h78);
    check("t4b_err_pre", 32'(cap_err), 32'd0);
    send_line(8, 8'h80);
    check("t4b_err", 32'(cap_err), 32'd1);
    send_vsync();
    check_frame("t4b", 8'h70);
    check("t4b_err_post", 32'(cap_err), 32'd1);

    // Disable mid-frame: frame completes, then back to IDLE and re-skip
    begin
      int fd0;
      fd0 = fd_cnt;
      send_line(8, 8'h00);
      cap_en = 1'b0;
      send_line(8, 8'h08);
      send_vsync();
      check_frame("t5", 8'h00);
      check("t5_fd", 32'(fd_cnt - fd0), 32'd1);
      check("t5_err_clr", 32'(cap_err), 32'd0);
    end
    cap_en = 1'b1;
    skip_two("t5r");
    send_frame(8'h00);
    check_frame("t5r", 8'h00);

    // Async reset mid-line
    send_line(8, 8'h90);
    @(negedge clk);
    href = 1'b1;
    data = 8'hA0;
    @(negedge clk);
    data = 8'hA1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t6_pre_valid", 32'(pix_valid), 32'd1);
    check("t6_pre_y", 32'(pix_y), 32'd1);
    #1 s_rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(pix_valid), 32'd0);
    check("t6_rst_data", 32'(pix_data), 32'd0);
    check("t6_rst_y", 32'(pix_y), 32'd0);
    check("t6_rst_x", 32'(pix_x), 32'd0);
    @(negedge clk);
    href = 1'b0;
    data = 8'd0;
    @(negedge clk);
    s_rst_n = 1'b1;
    q.delete();
    skip_two("t6");
    send_frame(8'h00);
    check_frame("t6", 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
